// File: rtl/igbt_pulse_sequencer.sv
// IGBT charge / dead-time / discharge pulse sequencer with a one-byte UART status queue.
// Optional macro DEAD_TIME_EN inserts a DEAD_CYCLES gap between the charge and discharge gates.
module igbt_pulse_sequencer #(
  parameter int TICK_DIV    = 50,
  parameter int DEAD_CYCLES = 25
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_work,
  input  logic [23:0] charge_time,
  input  logic [23:0] discharge_time,
  input  logic        tx_busy,
  output logic        send_en,
  output logic [7:0]  send_data,
  output logic        charge_gate,
  output logic        discharge_gate,
  output logic        seq_busy,
  output logic        seq_done
);

  if (TICK_DIV < 1 || DEAD_CYCLES < 1) begin : g_bad_params
    $error("igbt_pulse_sequencer: TICK_DIV and DEAD_CYCLES must be at least 1");
  end

  localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
`ifdef DEAD_TIME_EN
  localparam int              DW        = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]   DEAD_LAST = DW'(DEAD_CYCLES - 1);
`endif

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_STOP  = 8'h00;
  localparam logic [7:0] ST_DONE   = 8'hA5;
  localparam logic [7:0] ST_ABORT  = 8'hE1;
  localparam logic [7:0] ST_REJECT = 8'hE2;

  typedef enum logic [2:0] {
    IDLE,
    CHARGE,
`ifdef DEAD_TIME_EN
    DEAD,
`endif
    DISCHARGE,
    FINISH
  } state_t;

  state_t        state, state_nxt, after_charge, after_dead;
  logic [23:0]   charge_lat, discharge_lat;
  logic [TW-1:0] tick_cnt;
  logic [23:0]   unit_cnt;
`ifdef DEAD_TIME_EN
  logic [DW-1:0] dead_cnt;
`endif
  logic          start, stop, tick_wrap, charge_end, dis_end, dis_zero;
  logic          stat_push, st_valid, tx_hold, tx_seen, fire;
  logic [7:0]    stat_byte, st_byte;

  assign start      = cmd_valid && (cmd_work == CMD_START);
  assign stop       = cmd_valid && (cmd_work == CMD_STOP);
  assign tick_wrap  = (tick_cnt == TICK_LAST);
  assign charge_end = tick_wrap && (unit_cnt == charge_lat - 24'd1);
  assign dis_end    = tick_wrap && (unit_cnt == discharge_lat - 24'd1);
  // In IDLE the times are not latched yet, so the live inputs decide the route.
  assign dis_zero   = (state == IDLE) ? (discharge_time == '0) : (discharge_lat == '0);
  assign fire       = !tx_hold && st_valid && !tx_busy;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt    = state;
    stat_push    = 1'b0;
    stat_byte    = ST_DONE;
    after_dead   = dis_zero ? FINISH : DISCHARGE;
`ifdef DEAD_TIME_EN
    after_charge = DEAD;
`else
    after_charge = after_dead;
`endif
    if (state != IDLE && stop) begin
      state_nxt = IDLE;
      stat_push = 1'b1;
      stat_byte = ST_ABORT;
    end else begin
      if (state != IDLE && start) begin
        stat_push = 1'b1;
        stat_byte = ST_REJECT;
      end
      case (state)
        IDLE: if (start) begin
          if (charge_time == '0 && discharge_time == '0) state_nxt = FINISH;
          else if (charge_time != '0)                    state_nxt = CHARGE;
          else                                           state_nxt = after_charge;
        end
        CHARGE:    if (charge_end) state_nxt = after_charge;
`ifdef DEAD_TIME_EN
        DEAD:      if (dead_cnt == DEAD_LAST) state_nxt = after_dead;
`endif
        DISCHARGE: if (dis_end) state_nxt = FINISH;
        FINISH: begin
          state_nxt = IDLE;
          stat_push = 1'b1;
          stat_byte = ST_DONE;
        end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the gates are glitch-free flops
  // that can never both be high, and reset clears them asynchronously.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      charge_gate    <= 1'b0;
      discharge_gate <= 1'b0;
      seq_busy       <= 1'b0;
      seq_done       <= 1'b0;
      charge_lat     <= '0;
      discharge_lat  <= '0;
      tick_cnt       <= '0;
      unit_cnt       <= '0;
`ifdef DEAD_TIME_EN
      dead_cnt       <= '0;
`endif
    end else begin
      state          <= state_nxt;
      charge_gate    <= (state_nxt == CHARGE);
      discharge_gate <= (state_nxt == DISCHARGE);
      seq_busy       <= (state_nxt != IDLE);
      seq_done       <= (state_nxt == FINISH);
      if (state == IDLE && start) begin
        charge_lat    <= charge_time;
        discharge_lat <= discharge_time;
      end
      if (state_nxt != state) begin
        tick_cnt <= '0;
        unit_cnt <= '0;
`ifdef DEAD_TIME_EN
        dead_cnt <= '0;
`endif
      end else begin
        if (state == CHARGE || state == DISCHARGE) begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            unit_cnt <= unit_cnt + 24'd1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
`ifdef DEAD_TIME_EN
        if (state == DEAD) dead_cnt <= dead_cnt + DW'(1);
`endif
      end
    end
  end

  // Status byte queue and UART handshake: after a send, wait for tx_busy to rise and fall.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      send_en   <= 1'b0;
      send_data <= 8'h00;
      st_valid  <= 1'b0;
      st_byte   <= 8'h00;
      tx_hold   <= 1'b0;
      tx_seen   <= 1'b0;
    end else begin
      send_en <= 1'b0;
      if (tx_hold) begin
        if (tx_busy) begin
          tx_seen <= 1'b1;
        end else if (tx_seen) begin
          tx_hold <= 1'b0;
          tx_seen <= 1'b0;
        end
      end else if (fire) begin
        send_en   <= 1'b1;
        send_data <= st_byte;
        tx_hold   <= 1'b1;
      end
      if (stat_push) begin
        st_valid <= 1'b1;
        st_byte  <= stat_byte;
      end else if (fire) begin
        st_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_igbt_pulse_sequencer.sv
// Self-checking bench for igbt_pulse_sequencer: gate timing measured per cycle,
// status bytes checked through an expected-byte scoreboard.
module tb_igbt_pulse_sequencer;

  localparam int TICK_DIV    = 2;
  localparam int DEAD_CYCLES = 3;
`ifdef DEAD_TIME_EN
  localparam int DEAD_EXP = DEAD_CYCLES;
`else
  localparam int DEAD_EXP = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_work = 8'hFF;
  logic [23:0] charge_time = '0;
  logic [23:0] discharge_time = '0;
  logic        uart_busy = 1'b0;
  logic        hold_busy = 1'b0;
  logic        tx_busy;
  logic        send_en;
  logic [7:0]  send_data;
  logic        charge_gate, discharge_gate, seq_busy, seq_done;

  assign tx_busy = uart_busy | hold_busy;

  igbt_pulse_sequencer #(.TICK_DIV(TICK_DIV), .DEAD_CYCLES(DEAD_CYCLES)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .cmd_valid      (cmd_valid),
    .cmd_work       (cmd_work),
    .charge_time    (charge_time),
    .discharge_time (discharge_time),
    .tx_busy        (tx_busy),
    .send_en        (send_en),
    .send_data      (send_data),
    .charge_gate    (charge_gate),
    .discharge_gate (discharge_gate),
    .seq_busy       (seq_busy),
    .seq_done       (seq_done)
  );

  always #5 sys_clk = ~sys_clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         exp_sends = 0;
  int         sent = 0;
  int         done_cnt = 0;
  int         ovl_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_status(input logic [7:0] b);
    exp_q.push_back(b);
    exp_sends++;
  endtask

  // Output monitor: scoreboard pop on send_en, seq_done and gate-overlap counting.
  initial forever begin
    @(negedge sys_clk);
    if (charge_gate && discharge_gate) ovl_cnt++;
    if (seq_done) done_cnt++;
    if (send_en) begin
      sent++;
      if (exp_q.size() > 0) check("send_data", {24'h0, send_data}, {24'h0, exp_q.pop_front()});
    end
  end

  // Simple UART: busy for 4 cycles after every transmit request.
  initial forever begin
    @(negedge sys_clk);
    if (send_en) begin
      uart_busy = 1'b1;
      repeat (4) @(negedge sys_clk);
      uart_busy = 1'b0;
    end
  end

  task automatic pulse_cmd(input logic [7:0] w, input logic [23:0] ct, input logic [23:0] dt);
    cmd_work       = w;
    charge_time    = ct;
    discharge_time = dt;
    cmd_valid      = 1'b1;
    @(negedge sys_clk);
    cmd_valid      = 1'b0;
  endtask

  // Runs one start and measures each phase; inj >= 0 injects a second start at that discharge cycle.
  task automatic run_seq(input logic [23:0] ct, input logic [23:0] dt, input int inj, input string tag);
    int c = 0;
    int d = 0;
    int e = 0;
    int done0;
    int exp_d;
    done0 = done_cnt;
    exp_d = (ct == 0 && dt == 0) ? 0 : DEAD_EXP;
    pulse_cmd(8'h01, ct, dt);
    if (ct != 0) check({tag, "_latency"}, {31'h0, charge_gate}, 32'd1);
    while (charge_gate && c < 1000) begin
      c++;
      @(negedge sys_clk);
    end
    while (!charge_gate && !discharge_gate && !seq_done && d < 1000) begin
      d++;
      @(negedge sys_clk);
    end
    while (discharge_gate && e < 1000) begin
      if (e == inj) begin
        cmd_work       = 8'h01;
        charge_time    = 24'd1;
        discharge_time = 24'd1;
        cmd_valid      = 1'b1;
      end
      e++;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
    end
    check({tag, "_charge_len"}, c, ct * TICK_DIV);
    check({tag, "_dead_len"}, d, exp_d);
    check({tag, "_dis_len"}, e, dt * TICK_DIV);
    check({tag, "_done"}, {31'h0, seq_done}, 32'd1);
    @(negedge sys_clk);
    check({tag, "_done_cnt"}, done_cnt, done0 + 1);
    check({tag, "_idle"}, {31'h0, seq_busy}, 32'd0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (8) @(negedge sys_clk);
    check({tag, "_sent"}, sent, exp_sends);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int done0;
    #2;
    check("rst_charge",    {31'h0, charge_gate},    32'd0);
    check("rst_discharge", {31'h0, discharge_gate}, 32'd0);
    check("rst_send_en",   {31'h0, send_en},        32'd0);
    check("rst_send_data", {24'h0, send_data},      32'h00);
    check("rst_busy",      {31'h0, seq_busy},       32'd0);
    check("rst_done",      {31'h0, seq_done},       32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    expect_status(8'hA5);
    run_seq(24'd4, 24'd5, -1, "s1");
    drain("s1");

    expect_status(8'hA5);
    run_seq(24'd0, 24'd3, -1, "zero_charge");
    drain("zero_charge");

    expect_status(8'hA5);
    run_seq(24'd2, 24'd0, -1, "zero_dis");
    drain("zero_dis");

    expect_status(8'hA5);
    run_seq(24'd0, 24'd0, -1, "s3");
    drain("s3");

    // Stop three cycles into CHARGE.
    expect_status(8'hE1);
    done0 = done_cnt;
    pulse_cmd(8'h01, 24'd4, 24'd5);
    repeat (2) @(negedge sys_clk);
    pulse_cmd(8'h00, 24'd0, 24'd0);
    check("s2_charge", {31'h0, charge_gate},    32'd0);
    check("s2_dis",    {31'h0, discharge_gate}, 32'd0);
    check("s2_busy",   {31'h0, seq_busy},       32'd0);
    drain("s2");
    check("s2_no_done", done_cnt, done0);

    // Stop while idle must do nothing.
    pulse_cmd(8'h00, 24'd0, 24'd0);
    repeat (5) @(negedge sys_clk);
    check("idle_stop_busy", {31'h0, seq_busy}, 32'd0);
    check("idle_stop_sent", sent, exp_sends);

    // Rejected start with the UART free: E2 goes out, then A5.
    expect_status(8'hE2);
    expect_status(8'hA5);
    run_seq(24'd2, 24'd1, 0, "reject");
    drain("reject");

    // Rejected start while the UART is held busy: E2 is overwritten by A5.
    hold_busy = 1'b1;
    expect_status(8'hA5);
    run_seq(24'd4, 24'd5, 2, "s4");
    hold_busy = 1'b0;
    drain("s4");

    // UART held busy for 100 cycles at completion.
    hold_busy = 1'b1;
    expect_status(8'hA5);
    run_seq(24'd0, 24'd0, -1, "s5");
    repeat (100) @(negedge sys_clk);
    check("s5_held", sent, exp_sends - 1);
    hold_busy = 1'b0;
    drain("s5");
    repeat (20) @(negedge sys_clk);
    check("s5_once", sent, exp_sends);

    // Reset pulsed mid-CHARGE, with a start strobe presented during reset.
    pulse_cmd(8'h01, 24'd4, 24'd5);
    repeat (2) @(negedge sys_clk);
    check("s6_charging", {31'h0, charge_gate}, 32'd1);
    #2;
    sys_rst   = 1'b1;
    cmd_work  = 8'h01;
    cmd_valid = 1'b1;
    #1;
    check("s6_async_charge", {31'h0, charge_gate},    32'd0);
    check("s6_async_dis",    {31'h0, discharge_gate}, 32'd0);
    check("s6_async_busy",   {31'h0, seq_busy},       32'd0);
    repeat (2) @(negedge sys_clk);
    cmd_valid = 1'b0;
    sys_rst   = 1'b0;
    repeat (20) @(negedge sys_clk);
    check("s6_idle",    {31'h0, seq_busy}, 32'd0);
    check("s6_no_send", sent, exp_sends);
    check("no_overlap", ovl_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/igbt_pulse_sequencer.md
IGBT_PULSE_SEQUENCER -- requirements
Module: igbt_pulse_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50, sets sys_clk cycles per time unit (1 us at 50 MHz); SHALL be at least 1.
REQ-002 Parameter DEAD_CYCLES, default 25, sets the sys_clk cycles of dead time between charge and discharge; SHALL be at least 1.
REQ-003 sys_clk  input  1  single system clock; every flop SHALL be on its rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  one-cycle strobe marking a complete, checked frame.
REQ-006 cmd_work  input  8  work code: 8'h01 = start, 8'h00 = stop; all other codes ignored.
REQ-007 charge_time  input  24  charge duration in time units; sampled only on cmd_valid.
REQ-008 discharge_time  input  24  discharge duration in time units; sampled only on cmd_valid.
REQ-009 tx_busy  input  1  UART transmitter busy.
REQ-010 send_en  output  1  one-cycle transmit request.
REQ-011 send_data  output  8  status byte to transmit.
REQ-012 charge_gate  output  1  charge IGBT gate drive.
REQ-013 discharge_gate  output  1  discharge IGBT gate drive.
REQ-014 seq_busy  output  1  high in any state other than IDLE.
REQ-015 seq_done  output  1  one-cycle pulse when a sequence ends normally.

Function
REQ-016 The FSM SHALL have the states IDLE, CHARGE, DEAD, DISCHARGE and FINISH, with registered outputs.
REQ-017 Start with cmd_valid in IDLE SHALL latch both times; charge_gate SHALL go high on the next cycle (latency 1).
REQ-018 CHARGE SHALL last exactly charge_time*TICK_DIV cycles.
REQ-019 The tick prescaler SHALL restart at every state entry.
REQ-020 Multiply-free counting SHALL be used: a 24-bit unit counter plus a prescaler counter.
REQ-021 DEAD SHALL hold both gates low for exactly DEAD_CYCLES cycles.
REQ-022 DISCHARGE SHALL last exactly discharge_time*TICK_DIV cycles and then enter FINISH.
REQ-023 FINISH SHALL last 1 cycle, pulse seq_done, queue status 8'hA5 and return to IDLE.
REQ-024 A zero charge_time SHALL skip CHARGE, going to DEAD (or to DISCHARGE when dead time is compiled out).
REQ-025 A zero discharge_time SHALL skip DISCHARGE and go to FINISH.
REQ-026 When both times are zero, a start SHALL go IDLE -> FINISH directly with no gate activity.
REQ-027 Stop in any non-IDLE state SHALL drop both gates on the next cycle, return to IDLE and queue status 8'hE1, with no seq_done.
REQ-028 Stop in IDLE SHALL do nothing.
REQ-029 Start while seq_busy SHALL be ignored, except that status 8'hE2 (rejected) is queued; latched times SHALL NOT change.
REQ-030 charge_gate and discharge_gate SHALL never be high in the same cycle, including during abort and reset.
REQ-031 The status queue SHALL be a single byte register with a valid flag; a new status SHALL overwrite any pending unsent status.
REQ-032 When status is valid and tx_busy=0, send_en SHALL pulse for one cycle, with send_data set in the same cycle and then held.
REQ-033 The valid flag SHALL clear on the send_en cycle; send_en SHALL NOT repeat until tx_busy has gone high and returned low.
REQ-034 When status is queued in the same cycle that send_en fires for an older byte, the new byte SHALL stay pending.
REQ-035 cmd_valid SHALL be ignored while sys_rst is high.

Reset
REQ-036 On sys_rst: state IDLE, both gates 0, send_en 0, send_data 8'h00, seq_busy 0, seq_done 0, counters 0 and the status flag cleared.
REQ-037 Reset asserted mid-sequence SHALL drop the gates immediately (asynchronously), and no status SHALL be sent for the interrupted sequence.

Configuration
REQ-038 Macro DEAD_TIME_EN SHALL control dead-time insertion.
REQ-039 With DEAD_TIME_EN defined, DEAD SHALL be inserted as above.
REQ-040 Without DEAD_TIME_EN, the DEAD state and its counter SHALL NOT be synthesized, and CHARGE SHALL go directly to DISCHARGE.
REQ-041 Without DEAD_TIME_EN, discharge_gate SHALL rise in the cycle after charge_gate falls; REQ-030 still applies.

Verification
REQ-042 Scenario 1: TICK_DIV=2, DEAD_CYCLES=3, start with charge=4, discharge=5 -> charge_gate high for 8 cycles, both gates low for 3 cycles, discharge_gate high for 10 cycles, seq_done, then send_en with 8'hA5.
REQ-043 Scenario 2: stop issued 3 cycles into CHARGE -> both gates 0 on the next cycle, IDLE, send_en with 8'hE1, no seq_done.
REQ-044 Scenario 3: start with charge=0, discharge=0 -> no gate activity, seq_done 1 cycle after cmd_valid, status 8'hA5.
REQ-045 Scenario 4: second start during DISCHARGE with new times -> the sequence completes using the original times; 8'hE2 is then overwritten by 8'hA5 if the first is still pending.
REQ-046 Scenario 5: tx_busy held high for 100 cycles at completion -> send_en stays low, then fires exactly once after tx_busy falls.
REQ-047 Scenario 6: sys_rst pulsed mid-CHARGE -> gates 0 asynchronously, IDLE, no send_en.
REQ-048 Scenario 7: DEAD_TIME_EN undefined, repeat Scenario 1 -> discharge_gate rises the cycle after charge_gate falls, with no overlap.
